// File: rtl/text_pkg.sv
// Shared constants for the text console path: screen geometry, blank character
// and the control codes that the writer and the display pipeline both use.
package text_pkg;

    localparam int COLS  = 100;
    localparam int ROWS  = 30;
    localparam int ROW_W = 5;
    localparam int COL_W = 7;

    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CR         = 8'h0D;
    localparam logic [7:0] LF         = 8'h0A;
    localparam logic [7:0] BS         = 8'h08;
    localparam logic [7:0] TAB        = 8'h09;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= 8'h20) && (c <= 8'h7E);
    endfunction

endpackage

// File: rtl/text_writer.sv
// Character stream to VRAM writer: tracks the cursor, handles control codes,
// scrolls by advancing top_row and blanking the row that just came into view.
module text_writer #(
    parameter int COLS = text_pkg::COLS,
    parameter int ROWS = text_pkg::ROWS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_char,
    output logic       in_ready,
    output logic       vram_we,
    output logic [4:0] vram_row,
    output logic [6:0] vram_col,
    output logic [7:0] vram_char,
    output logic [4:0] top_row,
    output logic [4:0] cursor_row,
    output logic [6:0] cursor_col
);
    import text_pkg::*;

    typedef enum logic [1:0] {CLEAR_ALL, IDLE, CLEAR_ROW} state_t;

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

    state_t           state, state_n;
    logic [ROW_W-1:0] clr_row, clr_row_n, top_row_n, cur_row_n, wr_row_n, nl_row;
    logic [COL_W-1:0] clr_col, clr_col_n, cur_col_n, wr_col_n;
    logic [7:0]       wr_char_n, tab_col;
    logic             we_n, ready_n, do_newline;

    function automatic logic [ROW_W-1:0] row_inc(input logic [ROW_W-1:0] r);
        return (r == LAST_ROW) ? '0 : r + 1'b1;
    endfunction

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_n    = state;
        clr_row_n  = clr_row;
        clr_col_n  = clr_col;
        top_row_n  = top_row;
        cur_row_n  = cursor_row;
        cur_col_n  = cursor_col;
        we_n       = 1'b0;
        wr_row_n   = vram_row;
        wr_col_n   = vram_col;
        wr_char_n  = vram_char;
        do_newline = 1'b0;
        nl_row     = row_inc(cursor_row);
        tab_col    = {1'b0, cursor_col | 7'd7} + 8'd1;

        case (state)
            CLEAR_ALL: begin
                we_n      = 1'b1;
                wr_row_n  = clr_row;
                wr_col_n  = clr_col;
                wr_char_n = CHAR_SPACE;
                if (clr_col == LAST_COL) begin
                    clr_col_n = '0;
                    if (clr_row == LAST_ROW) begin
                        clr_row_n = '0;
                        state_n   = IDLE;
                    end else begin
                        clr_row_n = clr_row + 1'b1;
                    end
                end else begin
                    clr_col_n = clr_col + 1'b1;
                end
            end
            CLEAR_ROW: begin
                we_n      = 1'b1;
                wr_row_n  = clr_row;
                wr_col_n  = clr_col;
                wr_char_n = CHAR_SPACE;
                if (clr_col == LAST_COL) begin
                    clr_col_n = '0;
                    state_n   = IDLE;
                end else begin
                    clr_col_n = clr_col + 1'b1;
                end
            end
            default: begin
                if (in_valid && in_ready) begin
                    if (is_printable(in_char)) begin
                        we_n      = 1'b1;
                        wr_row_n  = cursor_row;
                        wr_col_n  = cursor_col;
                        wr_char_n = in_char;
                        if (cursor_col == LAST_COL) begin
                            cur_col_n  = '0;
                            do_newline = 1'b1;
                        end else begin
                            cur_col_n = cursor_col + 1'b1;
                        end
                    end else begin
                        case (in_char)
                            CR:      cur_col_n = '0;
                            LF:      do_newline = 1'b1;
                            BS:      if (cursor_col != '0) cur_col_n = cursor_col - 1'b1;
                            TAB:     cur_col_n = (tab_col > {1'b0, LAST_COL}) ? LAST_COL : tab_col[6:0];
                            default: ;
                        endcase
                    end
                    if (do_newline) begin
                        cur_row_n = nl_row;
                        if (nl_row == top_row) begin
                            top_row_n = row_inc(top_row);
                            state_n   = CLEAR_ROW;
                            clr_row_n = nl_row;
                            clr_col_n = '0;
                            // A bare LF has no char write, so the first blank goes out now.
                            if (!we_n) begin
                                we_n      = 1'b1;
                                wr_row_n  = nl_row;
                                wr_col_n  = '0;
                                wr_char_n = CHAR_SPACE;
                                clr_col_n = COL_W'(1);
                            end
                        end
                    end
                end
            end
        endcase

        ready_n = (state == IDLE) && (state_n == IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= CLEAR_ALL;
            clr_row    <= '0;
            clr_col    <= '0;
            top_row    <= '0;
            cursor_row <= '0;
            cursor_col <= '0;
            vram_we    <= 1'b0;
            vram_row   <= '0;
            vram_col   <= '0;
            vram_char  <= '0;
            in_ready   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            state      <= state_n;
            clr_row    <= clr_row_n;
            clr_col    <= clr_col_n;
            top_row    <= top_row_n;
            cursor_row <= cur_row_n;
            cursor_col <= cur_col_n;
            vram_we    <= we_n;
            vram_row   <= wr_row_n;
            vram_col   <= wr_col_n;
            vram_char  <= wr_char_n;
            in_ready   <= ready_n;
        end
    end

endmodule

// File: tb/tb_text_writer.sv
// Scoreboard bench for text_writer: expected VRAM writes are queued by the
// stimulus and popped by an independent monitor on every vram_we.
module tb_text_writer;
    import text_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_char = 8'h00;
    logic       in_ready, vram_we;
    logic [4:0] vram_row, top_row, cursor_row;
    logic [6:0] vram_col, cursor_col;
    logic [7:0] vram_char;

    int          checks = 0;
    int          failures = 0;
    logic [19:0] exp_q[$];
    logic [19:0] mon_exp;

    text_writer #(.COLS(100), .ROWS(30)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_char(in_char),
        .in_ready(in_ready), .vram_we(vram_we), .vram_row(vram_row),
        .vram_col(vram_col), .vram_char(vram_char), .top_row(top_row),
        .cursor_row(cursor_row), .cursor_col(cursor_col)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (vram_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got %0h expected none", {vram_row, vram_col, vram_char});
            end else begin
                mon_exp = exp_q.pop_front();
                check("vram_write", {12'h0, vram_row, vram_col, vram_char}, {12'h0, mon_exp});
            end
        end
    end

    function automatic logic [19:0] wr(input int r, input int c, input logic [7:0] ch);
        return {5'(r), 7'(c), ch};
    endfunction

    task automatic push_clear_all();
        for (int r = 0; r < 30; r++)
            for (int c = 0; c < 100; c++)
                exp_q.push_back(wr(r, c, CHAR_SPACE));
    endtask

    task automatic push_row_clear(input int r, input int n);
        for (int c = 0; c < n; c++) exp_q.push_back(wr(r, c, CHAR_SPACE));
    endtask

    // Called at a negedge; returns at the negedge after acceptance (outputs updated).
    task automatic send(input logic [7:0] c);
        int n = 0;
        while (!in_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: got in_ready=0 expected 1 for char %0h", c);
            return;
        end
        in_valid = 1'b1;
        in_char  = c;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Counts negedges until in_ready is seen high; compares against exp_n.
    task automatic wait_ready(input string name, input int exp_n, input int limit);
        int n = 0;
        while (!in_ready && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(name, n, exp_n);
    endtask

    task automatic check_cursor(input string name, input int r, input int c);
        check({name, "_row"}, 32'(cursor_row), r);
        check({name, "_col"}, 32'(cursor_col), c);
    endtask

    initial begin
        #1;
        check("rst_vram_we", 32'(vram_we), 0);
        check("rst_top_row", 32'(top_row), 0);
        check_cursor("rst_cursor", 0, 0);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_vram_addr", {12'h0, vram_row, vram_col, vram_char}, 0);
        repeat (2) @(negedge clk);
        check("rst_hold_we", 32'(vram_we), 0);

        push_clear_all();
        #2 reset = 1'b0;
        wait_ready("clear_all_len", 3001, 4000);
        check("clear_all_drained", exp_q.size(), 0);

        exp_q.push_back(wr(0, 0, 8'h41));
        send(8'h41);
        exp_q.push_back(wr(0, 1, 8'h42));
        send(8'h42);
        check_cursor("after_AB", 0, 2);
        send(CR);
        check_cursor("after_cr", 0, 0);

        for (int i = 0; i < 100; i++) begin
            exp_q.push_back(wr(0, i, 8'h78));
            send(8'h78);
        end
        check_cursor("after_100x", 1, 0);
        check("after_100x_top", 32'(top_row), 0);

        send(BS);
        check_cursor("bs_at_0", 1, 0);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(wr(1, i, 8'h61 + 8'(i)));
            send(8'h61 + 8'(i));
        end
        send(TAB);
        check_cursor("tab_from_3", 1, 8);
        repeat (11) send(TAB);
        check_cursor("tab_to_96", 1, 96);
        exp_q.push_back(wr(1, 96, 8'h7A));
        send(8'h7A);
        send(TAB);
        check_cursor("tab_from_97", 1, 99);
        send(8'h07);
        check_cursor("bel_ignored", 1, 99);
        send(BS);
        check_cursor("bs_from_99", 1, 98);
        send(CR);

        repeat (28) send(LF);
        check_cursor("lf_to_last", 29, 0);
        check("lf_to_last_top", 32'(top_row), 0);
        push_row_clear(0, 100);
        send(LF);
        check("scroll_lf_top", 32'(top_row), 1);
        check_cursor("scroll_lf_cursor", 0, 0);
        wait_ready("scroll_lf_busy", 100, 500);
        check("scroll_lf_drained", exp_q.size(), 0);

        repeat (13) send(TAB);
        check_cursor("tab_to_end", 0, 99);
        exp_q.push_back(wr(0, 99, 8'h51));
        push_row_clear(1, 100);
        send(8'h51);
        check("scroll_wrap_top", 32'(top_row), 2);
        check_cursor("scroll_wrap_cursor", 1, 0);
        wait_ready("scroll_wrap_busy", 101, 500);
        check("scroll_wrap_drained", exp_q.size(), 0);

        push_row_clear(2, 50);
        send(LF);
        check("abort_top_before", 32'(top_row), 3);
        repeat (49) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_we", 32'(vram_we), 0);
        check("abort_top", 32'(top_row), 0);
        check("abort_ready", 32'(in_ready), 0);
        check_cursor("abort_cursor", 0, 0);
        check("abort_drained", exp_q.size(), 0);
        @(negedge clk);
        push_clear_all();
        #2 reset = 1'b0;
        wait_ready("reclear_len", 3001, 4000);
        check("reclear_drained", exp_q.size(), 0);

        exp_q.push_back(wr(0, 0, 8'h5A));
        send(8'h5A);
        check_cursor("post_reclear", 0, 1);
        repeat (3) @(negedge clk);
        check("final_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/text_writer.md
TEXT_WRITER -- requirements
Module: text_writer

Interface
REQ-001 Parameter COLS, default 100, meaning text columns per row.
REQ-002 Parameter ROWS, default 30, meaning text rows in the ring of VRAM rows.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  in_char holds a character to consume.
REQ-006 in_char  input  8  ASCII character or control code.
REQ-007 in_ready  output  1  block accepts in_char this cycle; transfer = in_valid & in_ready.
REQ-008 vram_we  output  1  one-cycle VRAM write strobe.
REQ-009 vram_row  output  5  physical VRAM row of the write.
REQ-010 vram_col  output  7  VRAM column of the write.
REQ-011 vram_char  output  8  character written.
REQ-012 top_row  output  5  physical VRAM row shown at the screen top; feeds the display's top_row input.
REQ-013 cursor_row / cursor_col  output  5 / 7  physical cursor position.

Function
REQ-014 States: CLEAR_ALL (post-reset fill), IDLE, CLEAR_ROW (scroll fill); in_ready is registered and high only in IDLE.
REQ-015 All outputs are registered; an accepted char in cycle N drives vram_we/row/col/char and the updated cursor in cycle N+1.
REQ-016 Printable 0x20..0x7E: write in_char at (cursor_row, cursor_col); col<COLS-1 -> col+1; col=COLS-1 -> col=0 plus newline (REQ-021).
REQ-017 0x0D CR: col=0, no write.
REQ-018 0x0A LF: newline, col unchanged, no write.
REQ-019 0x08 BS: col>0 -> col-1; col=0 -> no change; no write.
REQ-020 0x09 TAB: col = min((col|7)+1, COLS-1); no write. Any other code is consumed with no effect.
REQ-021 Newline: next = (cursor_row==ROWS-1) ? 0 : cursor_row+1; cursor_row=next; if next==top_row (scroll), top_row advances by 1 mod ROWS and the state goes to CLEAR_ROW.
REQ-022 CLEAR_ROW: writes 0x20 to row next, cols 0..COLS-1, one per cycle, starting the cycle after acceptance (COLS cycles); then IDLE.
REQ-023 The printable write at col COLS-1 that triggers a scroll is issued in cycle N+1; the clear writes follow in cycles N+2..N+COLS+1.
REQ-024 CLEAR_ALL: writes 0x20 to every cell row-major, rows 0..ROWS-1, cols 0..COLS-1, one per cycle (ROWS*COLS cycles); then IDLE.
REQ-025 vram_we is low in every cycle without a write; vram_row/col/char hold their last values when vram_we is low.
REQ-026 Column and row counters never leave 0..COLS-1 / 0..ROWS-1; all row arithmetic wraps mod ROWS.

Reset
REQ-027 While reset is high: top_row=0, cursor=(0,0), vram_we=0, vram_row/col/char=0, in_ready=0, state=CLEAR_ALL with its counters at (0,0).
REQ-028 Reset asserted in any state, including mid-CLEAR_ROW, aborts the operation immediately; CLEAR_ALL restarts from (0,0) after release.

Structure
REQ-029 Package text_pkg holds COLS, ROWS, CHAR_SPACE=0x20 and the control-code constants CR, LF, BS, TAB; the display pipeline shares it.
REQ-030 Single module; the state enum is local; no sub-module.

Verification
REQ-031 Release reset -> 3000 writes of 0x20 covering (0,0)..(29,99) in order; in_ready rises in the cycle after the last write.
REQ-032 Send 'A','B' -> writes (0,0,0x41) and (0,1,0x42); cursor (0,2).
REQ-033 Send 100 'x' from (0,0) -> last write (0,99); cursor (1,0); top_row stays 0.
REQ-034 29 LF, then one more LF -> top_row 0->1, cursor_row 0, 100 writes of 0x20 to row 0, in_ready low for exactly 100 cycles.
REQ-035 BS at col 0 -> no write, col stays 0. TAB from col 3 -> col 8. TAB from col 97 -> col 99. Send 0x07 -> no effect.
REQ-036 Assert reset at clear cycle 50 of REQ-034 -> vram_we=0 and top_row=0 immediately; after release a full 3000-cycle CLEAR_ALL runs.
